// File: rtl/bus_irq_controller.sv
// rtl/bus_irq_controller.sv - memory-mapped interrupt controller for the 8-bit processor bus
// Define IRQC_PRIORITY_ROTATE_EN for round-robin vector selection; fixed priority otherwise.
module bus_irq_controller #(
  parameter logic [7:0] BASE_ADDR = 8'hE0,
  parameter int         NUM_SRC   = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic               IRQ_RAISE,
  input  logic               IRQ_ACK
);

  typedef enum logic [1:0] {ST_IDLE, ST_RAISED, ST_SERVICE} state_t;

  localparam logic [NUM_SRC-1:0] ONE = 1;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending, mask, trig, prev_irq, src_ack_r, lat_oh;
  logic [NUM_SRC-1:0] set_vec, clr_vec, active, vec_oh, wdata;
  logic [2:0]         vec_idx;
  logic               vec_valid;
  logic               hit, wr_hit, rd_en, take_ack;
  logic [7:0]         rd_data, rd_mux;

  assign hit      = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign wr_hit   = hit & BUS_WE;
  assign wdata    = BUS_DATA[NUM_SRC-1:0];
  // Level sources set while high; edge sources only on a 0->1 sample.
  assign set_vec  = SRC_IRQ & (~trig | ~prev_irq);
  assign clr_vec  = (wr_hit && BUS_ADDR[1:0] == 2'd0) ? wdata : '0;
  assign active   = pending & mask;
  assign take_ack = (state == ST_RAISED) && (|active) && IRQ_ACK;

`ifdef IRQC_PRIORITY_ROTATE_EN
  logic [2:0] rr_ptr;
`endif

  // Scan from the highest search position down so the first in order wins.
  always_comb begin : vec_search
    int j;
    j         = 0;
    vec_valid = 1'b0;
    vec_idx   = '0;
    vec_oh    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
`ifdef IRQC_PRIORITY_ROTATE_EN
      j = int'(rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
`else
      j = k;
`endif
      if (|(active & (ONE << j))) begin
        vec_valid = 1'b1;
        vec_idx   = 3'(j);
        vec_oh    = ONE << j;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (BUS_ADDR[1:0])
      2'd0:    rd_mux[NUM_SRC-1:0] = pending;
      2'd1:    rd_mux[NUM_SRC-1:0] = mask;
      2'd2:    rd_mux[NUM_SRC-1:0] = trig;
      default: rd_mux = vec_valid ? {1'b1, 4'b0000, vec_idx} : 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (|active) state_nxt = ST_RAISED;
      ST_RAISED: begin
        if (!(|active))   state_nxt = ST_IDLE;
        else if (IRQ_ACK) state_nxt = ST_SERVICE;
      end
      ST_SERVICE: if (!(|(lat_oh & active))) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      pending   <= '0;
      mask      <= '0;
      trig      <= '0;
      prev_irq  <= '0;
      src_ack_r <= '0;
      lat_oh    <= '0;
      rd_en     <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_nxt;
      prev_irq  <= SRC_IRQ;
      // A set in the same cycle as a clear keeps the bit and suppresses the ack.
      pending   <= set_vec | (pending & ~clr_vec);
      src_ack_r <= clr_vec & pending & ~set_vec;
      if (wr_hit && BUS_ADDR[1:0] == 2'd1) mask <= wdata;
      if (wr_hit && BUS_ADDR[1:0] == 2'd2) trig <= wdata;
      if (take_ack) lat_oh <= vec_oh;
      rd_en     <= hit & ~BUS_WE;
      rd_data   <= rd_mux;
    end
  end

`ifdef IRQC_PRIORITY_ROTATE_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_ptr <= '0;
    end else if (take_ack) begin
      rr_ptr <= (vec_idx == 3'(NUM_SRC - 1)) ? 3'd0 : vec_idx + 3'd1;
    end
  end
`endif

  assign SRC_ACK   = src_ack_r;
  assign IRQ_RAISE = (state == ST_RAISED);
  assign BUS_DATA  = rd_en ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_bus_irq_controller.sv
// tb/tb_bus_irq_controller.sv - randomized and directed bench against a behavioural model
module tb_bus_irq_controller;

  localparam int         N      = 8;
  localparam logic [7:0] BASE   = 8'hE0;
  localparam logic [7:0] A_P    = BASE;
  localparam logic [7:0] A_M    = BASE + 8'd1;
  localparam logic [7:0] A_T    = BASE + 8'd2;
  localparam logic [7:0] A_V    = BASE + 8'd3;
  localparam logic [7:0] NOHIT  = 8'h10;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  wire  [7:0]   BUS_DATA;
  logic [7:0]   BUS_ADDR = '0;
  logic         BUS_WE = 1'b0;
  logic [N-1:0] SRC_IRQ = '0;
  logic [N-1:0] SRC_ACK;
  logic         IRQ_RAISE;
  logic         IRQ_ACK = 1'b0;
  logic [7:0]   tb_wdata = '0;
  logic         tb_drive = 1'b0;

  assign BUS_DATA = tb_drive ? tb_wdata : 8'bzzzz_zzzz;

  always #5 CLK = ~CLK;

  bus_irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR),
    .BUS_WE(BUS_WE), .SRC_IRQ(SRC_IRQ), .SRC_ACK(SRC_ACK),
    .IRQ_RAISE(IRQ_RAISE), .IRQ_ACK(IRQ_ACK)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = raised, 2 = in service
  logic [N-1:0] m_pend, m_msk, m_trg, m_prv, m_ack;
  int           m_mode, m_lat, m_ptr;
  bit           m_rd_v;
  logic [7:0]   m_rd, last_rd;
  logic [N-1:0] src_cur;

  task automatic model_reset();
    m_pend = '0; m_msk = '0; m_trg = '0; m_prv = '0; m_ack = '0;
    m_mode = 0; m_lat = 0; m_ptr = 0; m_rd_v = 0; m_rd = '0;
  endtask

  function automatic int winner();
    int j;
    for (int k = 0; k < N; k++) begin
`ifdef IRQC_PRIORITY_ROTATE_EN
      j = (m_ptr + k) % N;
`else
      j = k;
`endif
      if (m_pend[j] && m_msk[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] a, input bit we, input logic [7:0] d,
                            input logic [N-1:0] s, input bit ack);
    bit           hit, set, clr;
    int           off, w;
    logic [N-1:0] nxt_pend, nxt_ack;
    hit    = ((a >> 2) == (BASE >> 2));
    off    = int'(a & 8'h03);
    w      = winner();
    m_rd_v = hit && !we;
    if (m_rd_v) begin
      case (off)
        0:       m_rd = 8'(m_pend);
        1:       m_rd = 8'(m_msk);
        2:       m_rd = 8'(m_trg);
        default: m_rd = (w < 0) ? 8'h00 : 8'(128 + w);
      endcase
    end
    case (m_mode)
      0: if (w >= 0) m_mode = 1;
      1: begin
        if (w < 0) m_mode = 0;
        else if (ack) begin
          m_mode = 2; m_lat = w; m_ptr = (w + 1) % N;
        end
      end
      default: if (!(m_pend[m_lat] && m_msk[m_lat])) m_mode = 0;
    endcase
    for (int i = 0; i < N; i++) begin
      set = s[i] && (!m_trg[i] || !m_prv[i]);
      clr = hit && we && off == 0 && d[i];
      nxt_pend[i] = set || (m_pend[i] && !clr);
      nxt_ack[i]  = clr && m_pend[i] && !set;
    end
    m_pend = nxt_pend;
    m_ack  = nxt_ack;
    if (hit && we && off == 1) m_msk = d[N-1:0];
    if (hit && we && off == 2) m_trg = d[N-1:0];
    m_prv = s;
  endtask

  // One bus cycle: drive at negedge, step model at posedge, compare #1 later.
  task automatic cyc(input logic [7:0] a, input bit we, input logic [7:0] d, input bit ack);
    BUS_ADDR = a; BUS_WE = we; tb_wdata = d; tb_drive = we;
    SRC_IRQ = src_cur; IRQ_ACK = ack;
    @(posedge CLK);
    model_step(a, we, d, src_cur, ack);
    #1;
    tb_drive = 1'b0;
    check("irq_raise", IRQ_RAISE, m_mode == 1);
    check("src_ack", SRC_ACK, m_ack);
    if (m_rd_v) begin
      check("rd_data", BUS_DATA, m_rd);
      last_rd = BUS_DATA;
    end
    @(negedge CLK);
  endtask

  task automatic idle();                           cyc(NOHIT, 1'b0, 8'h00, 1'b0); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d); cyc(a, 1'b1, d, 1'b0); endtask
  task automatic rd(input logic [7:0] a);          cyc(a, 1'b0, 8'h00, 1'b0); endtask
  task automatic ackc();                           cyc(NOHIT, 1'b0, 8'h00, 1'b1); endtask

  task automatic do_reset();
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check("rst_raise", IRQ_RAISE, 1'b0);
    check("rst_ack", SRC_ACK, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    int          r;
    logic [7:0]  d;
    src_cur = '0;
    last_rd = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("init_raise", IRQ_RAISE, 1'b0);
    check("init_ack", SRC_ACK, '0);
    RESET_N = 1'b1;
    rd(A_P); rd(A_M); rd(A_T); rd(A_V);
    check("init_vec", last_rd, 8'h00);
    idle();

    // Edge source 2 raises after two clocks, vector 0x82, W1C acks.
    wr(A_M, 8'h04); wr(A_T, 8'h04);
    src_cur = 8'h04; idle();
    src_cur = 8'h00; idle();
    check("t1_raise", IRQ_RAISE, 1'b1);
    rd(A_V);
    check("t1_vec", last_rd, 8'h82);
    idle();
    wr(A_P, 8'h04);
    check("t1_ack", SRC_ACK, 8'h04);
    idle();
    check("t1_idle", IRQ_RAISE, 1'b0);

    // Held level source re-pends after W1C.
    src_cur = 8'h01;
    wr(A_T, 8'h00); wr(A_M, 8'h01); idle();
    wr(A_P, 8'h01); rd(A_P);
    check("t2_repend", last_rd, 8'h01);
    src_cur = 8'h00; idle();
    wr(A_P, 8'h01); idle();

    // Sources 1 and 5: vector 0x81, ack + clear 1 gives 0x85.
    wr(A_M, 8'h22); wr(A_T, 8'h22);
    src_cur = 8'h22; idle();
    src_cur = 8'h00; idle(); idle();
    rd(A_V);
    check("t3_vec1", last_rd, 8'h81);
    idle(); ackc();
    check("t3_service", IRQ_RAISE, 1'b0);
    wr(A_P, 8'h02); idle(); idle();
    rd(A_V);
    check("t3_vec2", last_rd, 8'h85);
    idle(); ackc(); wr(A_P, 8'h20); idle();

    // Masking a raised source drops IRQ_RAISE.
    wr(A_P, 8'hFF); wr(A_M, 8'h08); wr(A_T, 8'h08);
    src_cur = 8'h08; idle();
    src_cur = 8'h00; idle(); idle();
    wr(A_M, 8'h00); idle();
    check("t4_drop", IRQ_RAISE, 1'b0);

    // Edge and W1C in the same cycle: set wins, no ack.
    wr(A_M, 8'h08); wr(A_P, 8'h08); idle();
    src_cur = 8'h08; wr(A_P, 8'h08);
    check("t5_noack", SRC_ACK, 8'h00);
    src_cur = 8'h00; rd(A_P);
    check("t5_pend", last_rd & 8'h08, 8'h08);
    idle();

    // Reset while in service clears everything.
    wr(A_P, 8'hFF); wr(A_M, 8'h08); wr(A_T, 8'h08);
    src_cur = 8'h08; idle();
    src_cur = 8'h00; idle(); ackc();
    do_reset();
    rd(A_P); check("t6_pend", last_rd, 8'h00);
    rd(A_M); check("t6_mask", last_rd, 8'h00);
    rd(A_T); check("t6_trig", last_rd, 8'h00);
    idle();

    // Random traffic; a write never directly follows a read.
    for (int n = 0; n < 2000; n++) begin
      src_cur = N'($urandom & $urandom);
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (m_rd_v && r < 5) r = r + 5;
      if ($urandom_range(0, 399) == 0) do_reset();
      case (r)
        0, 1:    wr(A_P, d);
        2:       wr(A_M, d);
        3:       wr(A_T, d);
        4:       wr(A_V, d);
        5, 6:    rd(BASE + 8'($urandom_range(0, 3)));
        default: cyc(8'($urandom_range(0, 15)), 1'b0, 8'h00, $urandom_range(0, 2) == 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
